// File: rtl/redmule_x_loader_pkg.sv
// Purpose: shared types and constants for the RedMulE X loader.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package redmule_x_loader_pkg;

    localparam int unsigned ARRAY_HEIGHT = 4;
    localparam int unsigned ARRAY_WIDTH  = 12;
    localparam int unsigned X_D          = 2;

    // Largest number of loads a single block can need (a full block of W rows).
    localparam int unsigned X_LPB_MAX = (ARRAY_WIDTH / ARRAY_HEIGHT) * X_D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } x_loader_state_e;

    // Loads per block: rows are packed H per load slot, D slots per group.
    function automatic int unsigned x_lpb(input int unsigned rows,
                                          input int unsigned h,
                                          input int unsigned d);
        return ((rows + h - 1) / h) * d;
    endfunction

endpackage

// File: rtl/redmule_x_fifo.sv
// Purpose: small DW x Depth input FIFO with registered head, zero when empty.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: o_full derives from the registered count only, so a pop never opens a slot in the same cycle.
// Ports: i_flush empties the FIFO; i_push/i_data write (ignored when full);
//        i_pop removes the head (ignored when empty); o_data is the head.
module redmule_x_fifo #(
    parameter int unsigned DW    = 288,
    parameter int unsigned Depth = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DW-1:0] r_mem [Depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_cnt == (AW+1)'(Depth));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/redmule_x_loader.sv
// Purpose: X buffer loader; buffers streamed X words and sequences clear/load/blck_shift/h_shift per block.
// Latency: clear strobe 1 cycle after start; loads follow as FIFO data arrives; done 1 cycle after last h_shift.
// Backpressure: x_ready_o = FIFO not full; loads stall on empty FIFO or buf_full_i; h_shift waits on engine_ready_i.
// Ports: stream in (x_valid_i/x_ready_o/x_data_i), FIFO head out (x_data_o),
//        X buffer strobes (buf_clear_o, load_o, blck_shift_o, h_shift_o), status (busy_o, done_o).
module redmule_x_loader
    import redmule_x_loader_pkg::*;
#(
    parameter int unsigned DW        = 288,
    parameter int unsigned Height    = ARRAY_HEIGHT,
    parameter int unsigned Width     = ARRAY_WIDTH,
    parameter int unsigned D         = X_D,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [15:0]                n_blocks_i,
    input  logic [$clog2(Width):0]     rows_lftovr_i,
    input  logic                       x_valid_i,
    output logic                       x_ready_o,
    input  logic [DW-1:0]              x_data_i,
    output logic [DW-1:0]              x_data_o,
    input  logic                       buf_full_i,
    input  logic                       engine_ready_i,
    output logic                       buf_clear_o,
    output logic                       load_o,
    output logic                       blck_shift_o,
    output logic                       h_shift_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int LW = $clog2(Width / Height * D) + 1;
    localparam int HW = $clog2(Height) + 1;
    localparam int RW = $clog2(Width) + 1;

    x_loader_state_e r_state;
    logic [LW-1:0]   r_ld_cnt;
    logic [HW-1:0]   r_h_cnt;
    logic [15:0]     r_blk_cnt;
    logic [15:0]     r_n_blocks;
    logic [RW-1:0]   r_rows;
    logic            r_buf_clear;
    logic            r_blck_shift;
    logic            r_done;

    logic            w_empty;
    logic            w_full;
    logic            w_load;
    logic            w_h_shift;
    logic            w_last_blk;
    logic [LW-1:0]   w_lpb;

    redmule_x_fifo #(
        .DW    (DW),
        .Depth (FifoDepth)
    ) i_x_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_flush (clear_i),
        .i_push  (x_valid_i & ~w_full),
        .i_data  (x_data_i),
        .i_pop   (w_load),
        .o_data  (x_data_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_last_blk = (r_blk_cnt == (r_n_blocks - 16'd1));
    // Only the last block may be short; all earlier blocks carry W rows.
    assign w_lpb = w_last_blk ? LW'(x_lpb(32'(r_rows), Height, D))
                              : LW'(x_lpb(Width, Height, D));

    // The clear cycle (first FILL cycle) must not also load, and the
    // blck_shift cycle (first FEED cycle) must not also h_shift.
    assign w_load    = (r_state == FILL) & ~r_buf_clear & ~w_empty & ~buf_full_i;
    assign w_h_shift = (r_state == FEED) & ~r_blck_shift & engine_ready_i;

    assign x_ready_o    = ~w_full;
    assign load_o       = w_load;
    assign h_shift_o    = w_h_shift;
    assign blck_shift_o = r_blck_shift;
    assign buf_clear_o  = r_buf_clear;
    assign done_o       = r_done;
    assign busy_o       = (r_state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_ld_cnt     <= '0;
            r_h_cnt      <= '0;
            r_blk_cnt    <= '0;
            r_n_blocks   <= '0;
            r_rows       <= '0;
            r_buf_clear  <= 1'b0;
            r_blck_shift <= 1'b0;
            r_done       <= 1'b0;
        end else if (clear_i) begin
            r_state      <= IDLE;
            r_ld_cnt     <= '0;
            r_h_cnt      <= '0;
            r_blk_cnt    <= '0;
            r_n_blocks   <= '0;
            r_rows       <= '0;
            r_buf_clear  <= 1'b0;
            r_blck_shift <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_buf_clear  <= 1'b0;
            r_blck_shift <= 1'b0;
            r_done       <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_n_blocks  <= (n_blocks_i == 16'd0) ? 16'd1 : n_blocks_i;
                        r_rows      <= (rows_lftovr_i == '0) ? RW'(Width) : rows_lftovr_i;
                        r_ld_cnt    <= '0;
                        r_h_cnt     <= '0;
                        r_blk_cnt   <= '0;
                        r_buf_clear <= 1'b1;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    if (w_load) begin
                        r_ld_cnt <= r_ld_cnt + LW'(1);
                        if ((r_ld_cnt + LW'(1)) == w_lpb) begin
                            r_blck_shift <= 1'b1;
                            r_state      <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (w_h_shift) begin
                        if ((r_h_cnt + HW'(1)) == HW'(Height)) begin
                            if (w_last_blk) begin
                                r_h_cnt <= r_h_cnt + HW'(1);
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_blk_cnt <= r_blk_cnt + 16'd1;
                                r_ld_cnt  <= '0;
                                r_h_cnt   <= '0;
                                r_state   <= FILL;
                            end
                        end else begin
                            r_h_cnt <= r_h_cnt + HW'(1);
                        end
                    end
                end
                DONE: begin
                    r_ld_cnt  <= '0;
                    r_h_cnt   <= '0;
                    r_blk_cnt <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_x_loader.sv
// Purpose: self-checking bench for redmule_x_loader using a word scoreboard and strobe counters.
// Latency: n/a.
// Backpressure: exercises buf_full_i, engine_ready_i toggling, stream stalls, abort and mid-run reset.
module tb_redmule_x_loader;

    localparam int DW = 288;
    typedef logic [DW-1:0] wd_t;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [15:0] n_blocks_i;
    logic [4:0]  rows_lftovr_i;
    logic        x_valid_i;
    logic        x_ready_o;
    wd_t         x_data_i;
    wd_t         x_data_o;
    logic        buf_full_i;
    logic        engine_ready_i;
    logic        buf_clear_o;
    logic        load_o;
    logic        blck_shift_o;
    logic        h_shift_o;
    logic        busy_o;
    logic        done_o;

    redmule_x_loader #(
        .DW        (DW),
        .Height    (4),
        .Width     (12),
        .D         (2),
        .FifoDepth (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .n_blocks_i     (n_blocks_i),
        .rows_lftovr_i  (rows_lftovr_i),
        .x_valid_i      (x_valid_i),
        .x_ready_o      (x_ready_o),
        .x_data_i       (x_data_i),
        .x_data_o       (x_data_o),
        .buf_full_i     (buf_full_i),
        .engine_ready_i (engine_ready_i),
        .buf_clear_o    (buf_clear_o),
        .load_o         (load_o),
        .blck_shift_o   (blck_shift_o),
        .h_shift_o      (h_shift_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int  n_chk  = 0;
    int  n_pass = 0;

    // Scoreboard and event counters, written by the monitor only.
    wd_t exp_q[$];
    int  bsh_loads[$];
    int  n_acc = 0, n_load = 0, n_bsh = 0, n_hsh = 0, n_clr = 0, n_done = 0;
    bit  acc = 1'b0;

    // Stream driver controls, written by the main sequence only.
    int  words_target = 0;
    bit  stall = 1'b0;

    // Snapshots taken at the start of each job.
    int  s_acc, s_load, s_bsh, s_hsh, s_clr, s_done, s_bidx;

    task automatic chk(input string tag, input wd_t act, input wd_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: records accepted words, checks every load against the queue head.
    always @(negedge clk_i) begin
        acc = 1'b0;
        if (!rst_ni || clear_i) begin
            exp_q.delete();
        end else begin
            if (load_o) begin
                if (exp_q.size() == 0) chk("load_underflow", wd_t'(1), wd_t'(0));
                else chk("load_data", x_data_o, exp_q.pop_front());
            end
            if (x_valid_i && x_ready_o) begin
                exp_q.push_back(x_data_i);
                n_acc++;
                acc = 1'b1;
            end
            if (load_o || blck_shift_o || h_shift_o)
                chk("strobe_excl", wd_t'($countones({load_o, blck_shift_o, h_shift_o})), wd_t'(1));
            if (blck_shift_o) begin
                bsh_loads.push_back(n_load);
                n_bsh++;
            end
            n_load += int'(load_o);
            n_hsh  += int'(h_shift_o);
            n_clr  += int'(buf_clear_o);
            n_done += int'(done_o);
        end
    end

    // Stream driver: fresh random word after each acceptance, holds otherwise.
    initial begin
        x_valid_i = 1'b0;
        x_data_i  = '0;
        forever begin
            @(posedge clk_i);
            #2;
            if (n_acc < words_target && !stall) begin
                if (!x_valid_i || acc)
                    for (int k = 0; k < DW / 32; k++) x_data_i[32*k +: 32] = $urandom;
                x_valid_i = 1'b1;
            end else begin
                x_valid_i = 1'b0;
            end
        end
    end

    task automatic snap();
        s_acc = n_acc; s_load = n_load; s_bsh = n_bsh; s_hsh = n_hsh;
        s_clr = n_clr; s_done = n_done; s_bidx = bsh_loads.size();
    endtask

    task automatic start_job(input int nb, input int rows, input int nwords);
        snap();
        words_target = words_target + nwords;
        cyc();
        n_blocks_i    = 16'(nb);
        rows_lftovr_i = 5'(rows);
        start_i       = 1'b1;
        cyc();
        start_i       = 1'b0;
    endtask

    task automatic wait_loads(input int n);
        for (int i = 0; i < 400; i++) begin
            if (n_load - s_load >= n) return;
            cyc();
        end
        chk("timeout_loads", wd_t'(n_load - s_load), wd_t'(n));
    endtask

    task automatic wait_bsh(input int n);
        for (int i = 0; i < 400; i++) begin
            if (n_bsh - s_bsh >= n) return;
            cyc();
        end
        chk("timeout_bsh", wd_t'(n_bsh - s_bsh), wd_t'(n));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            if (n_done - s_done >= 1) break;
            cyc();
        end
        #2;
        chk("busy_after_done", wd_t'(busy_o), wd_t'(0));
        repeat (2) cyc();
    endtask

    task automatic check_counts(input string tag, input int lds, input int bsh, input int hsh);
        chk({tag, "_clr"},   wd_t'(n_clr - s_clr),   wd_t'(1));
        chk({tag, "_loads"}, wd_t'(n_load - s_load), wd_t'(lds));
        chk({tag, "_bsh"},   wd_t'(n_bsh - s_bsh),   wd_t'(bsh));
        chk({tag, "_hsh"},   wd_t'(n_hsh - s_hsh),   wd_t'(hsh));
        chk({tag, "_done"},  wd_t'(n_done - s_done), wd_t'(1));
        chk({tag, "_q_empty"}, wd_t'(exp_q.size()),  wd_t'(0));
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        n_blocks_i = '0; rows_lftovr_i = '0;
        buf_full_i = 1'b0; engine_ready_i = 1'b1;

        // Reset state.
        repeat (3) cyc();
        #2;
        chk("rst_ready", wd_t'(x_ready_o), wd_t'(1));
        chk("rst_strobes", wd_t'({buf_clear_o, load_o, blck_shift_o, h_shift_o, busy_o, done_o}), wd_t'(0));
        chk("rst_data", x_data_o, wd_t'(0));
        cyc();
        rst_ni = 1'b1;

        // Idle: two pushes fill the FIFO, no strobes without start.
        snap();
        words_target = 2;
        for (int i = 0; i < 50 && n_acc < 2; i++) cyc();
        #2;
        chk("idle_full_ready", wd_t'(x_ready_o), wd_t'(0));
        chk("idle_head", x_data_o, (exp_q.size() > 0) ? exp_q[0] : wd_t'(0));
        chk("idle_no_load", wd_t'({load_o, busy_o, buf_clear_o}), wd_t'(0));
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        #2;
        chk("flush_ready", wd_t'(x_ready_o), wd_t'(1));
        chk("flush_data", x_data_o, wd_t'(0));

        // Single full block.
        start_job(1, 0, 6);
        wait_done();
        check_counts("full_blk", 6, 1, 4);
        if (bsh_loads.size() > s_bidx) chk("full_blk_lpb", wd_t'(bsh_loads[s_bidx] - s_load), wd_t'(6));
        else chk("full_blk_lpb", wd_t'(0), wd_t'(6));

        // Two blocks, 3 leftover rows in the last one.
        start_job(2, 3, 8);
        wait_done();
        check_counts("lftovr", 8, 2, 8);
        if (bsh_loads.size() > s_bidx + 1) begin
            chk("lftovr_blk0", wd_t'(bsh_loads[s_bidx] - s_load), wd_t'(6));
            chk("lftovr_blk1", wd_t'(bsh_loads[s_bidx+1] - s_load), wd_t'(8));
        end else begin
            chk("lftovr_bsh_seen", wd_t'(bsh_loads.size() - s_bidx), wd_t'(2));
        end

        // Backpressure: buf_full during FILL, engine_ready 1010 in FEED.
        engine_ready_i = 1'b0;
        start_job(1, 0, 6);
        wait_loads(2);
        begin
            int l0;
            wd_t head;
            buf_full_i = 1'b1;
            l0 = n_load;
            #2;
            head = x_data_o;
            for (int i = 0; i < 5; i++) begin
                cyc();
                #2;
                chk("full_no_load", wd_t'(load_o), wd_t'(0));
                chk("full_hold", x_data_o, head);
            end
            cyc();
            buf_full_i = 1'b0;
            chk("full_load_cnt", wd_t'(n_load), wd_t'(l0));
        end
        wait_bsh(1);
        for (int i = 0; i < 8; i++) begin
            engine_ready_i = (i % 2 == 0);
            #2;
            chk("hshift_track", wd_t'(h_shift_o), wd_t'(engine_ready_i));
            cyc();
        end
        engine_ready_i = 1'b1;
        wait_done();
        check_counts("bp", 6, 1, 4);

        // Stream stall of 10 cycles during FILL.
        start_job(1, 0, 6);
        wait_loads(2);
        stall = 1'b1;
        repeat (3) cyc();
        begin
            int l0;
            l0 = n_load;
            #2;
            chk("stall_empty_head", x_data_o, wd_t'(0));
            for (int i = 0; i < 7; i++) begin
                cyc();
                #2;
                chk("stall_no_load", wd_t'(load_o), wd_t'(0));
            end
            cyc();
            chk("stall_load_cnt", wd_t'(n_load), wd_t'(l0));
        end
        stall = 1'b0;
        wait_done();
        check_counts("stall", 6, 1, 4);

        // Abort in FEED after two h_shifts, then a clean rerun.
        engine_ready_i = 1'b0;
        start_job(1, 0, 8);
        wait_bsh(1);
        engine_ready_i = 1'b1;
        cyc();
        cyc();
        engine_ready_i = 1'b0;
        cyc();
        #2;
        chk("feed_accepts", wd_t'(n_acc - s_acc), wd_t'(8));
        chk("feed_hsh", wd_t'(n_hsh - s_hsh), wd_t'(2));
        cyc();
        clear_i = 1'b1;
        start_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        start_i = 1'b0;
        #2;
        chk("abort_busy", wd_t'(busy_o), wd_t'(0));
        chk("abort_ready", wd_t'(x_ready_o), wd_t'(1));
        chk("abort_data", x_data_o, wd_t'(0));
        chk("abort_strobes", wd_t'({buf_clear_o, load_o, blck_shift_o, h_shift_o}), wd_t'(0));
        repeat (4) cyc();
        chk("abort_no_done", wd_t'(n_done - s_done), wd_t'(0));
        chk("abort_start_ignored", wd_t'(busy_o), wd_t'(0));
        engine_ready_i = 1'b1;
        start_job(1, 0, 6);
        wait_done();
        check_counts("rerun", 6, 1, 4);

        // Reset in the middle of FILL.
        start_job(1, 0, 6);
        wait_loads(2);
        words_target = n_acc;
        rst_ni = 1'b0;
        #2;
        chk("mid_rst_busy", wd_t'(busy_o), wd_t'(0));
        chk("mid_rst_ready", wd_t'(x_ready_o), wd_t'(1));
        chk("mid_rst_data", x_data_o, wd_t'(0));
        chk("mid_rst_strobes", wd_t'({buf_clear_o, load_o, blck_shift_o, h_shift_o, done_o}), wd_t'(0));
        cyc();
        rst_ni = 1'b1;
        cyc();
        start_job(1, 0, 6);
        wait_done();
        check_counts("post_rst", 6, 1, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
